// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int DEF_ADDR_W     = 32;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_STARVE_MAX = 4;

  // Owner of the read response that returns from the SRAM next cycle
  typedef enum logic [1:0] {
    NONE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } resp_owner_t;

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port synchronous SRAM between instruction fetch and
// the data stage. Data wins by default; a saturating starvation counter
// forces a fetch grant after STARVE_MAX consecutive denied fetch cycles.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                ram_en,
  output logic [DATA_W/8-1:0] ram_wen,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic                stallreq
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic        force_inst;
  resp_owner_t sel;
  resp_owner_t resp_owner;
  resp_owner_t resp_owner_nxt;

  assign force_inst = (starve_cnt == STARVE_LIM);

  // Pick this cycle's owner: starved fetch, then data, then fetch
  always_comb begin
    sel = NONE;
    if (force_inst && inst_req) begin
      sel = INST;
    end else if (data_req) begin
      sel = DATA;
    end else if (inst_req) begin
      sel = INST;
    end
  end

  // Grants, stall request and the SRAM command mux
  always_comb begin
    inst_gnt  = inst_req && (sel == INST);
    data_gnt  = data_req && (sel == DATA);
    stallreq  = (inst_req && !inst_gnt) || (data_req && !data_gnt);
    ram_en    = inst_gnt || data_gnt;
    ram_wen   = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (sel == DATA) begin
      ram_wen   = data_wen;
      ram_addr  = data_addr;
      ram_wdata = data_wdata;
    end else if (sel == INST) begin
      ram_addr  = inst_addr;
    end
  end

  // Count consecutive denied fetch cycles, saturating at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (inst_req && !inst_gnt) begin
      if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  // Response tag register; reset drops any outstanding response
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_owner <= NONE;
    end else begin
      resp_owner <= resp_owner_nxt;
    end
  end

  // Next tag: reads produce a response, writes do not
  always_comb begin
    resp_owner_nxt = NONE;
    if (inst_gnt) begin
      resp_owner_nxt = INST;
    end else if (data_gnt && (data_wen == '0)) begin
      resp_owner_nxt = DATA;
    end
  end

  // Route the returning read data to its owner
  always_comb begin
    inst_rvalid = (resp_owner == INST);
    data_rvalid = (resp_owner == DATA);
    inst_rdata  = ram_rdata;
    data_rdata  = ram_rdata;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural 1-cycle SRAM.
module tb_sram_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic          clk;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_gnt;
  logic          inst_rvalid;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic [BW-1:0] data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_gnt;
  logic          data_rvalid;
  logic [DW-1:0] data_rdata;
  logic          ram_en;
  logic [BW-1:0] ram_wen;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          stallreq;

  int n_cmp;
  int n_mis;

  logic [DW-1:0] mem [256];

  sram_port_arbiter #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .STARVE_MAX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .inst_req   (inst_req),
    .inst_addr  (inst_addr),
    .inst_gnt   (inst_gnt),
    .inst_rvalid(inst_rvalid),
    .inst_rdata (inst_rdata),
    .data_req   (data_req),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_gnt   (data_gnt),
    .data_rvalid(data_rvalid),
    .data_rdata (data_rdata),
    .ram_en     (ram_en),
    .ram_wen    (ram_wen),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .stallreq   (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed SRAM with byte writes and 1-cycle read latency
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wen == '0) begin
        ram_rdata <= mem[ram_addr[9:2]];
      end else begin
        for (int b = 0; b < BW; b++) begin
          if (ram_wen[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle's drive point, apply inputs, settle
  task automatic cyc(input logic r, input logic ir, input logic [AW-1:0] ia,
                     input logic dr, input logic [BW-1:0] dw,
                     input logic [AW-1:0] da, input logic [DW-1:0] dd);
    @(negedge clk);
    rst = r; inst_req = ir; inst_addr = ia;
    data_req = dr; data_wen = dw; data_addr = da; data_wdata = dd;
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, '0);
  endtask

  logic [5:0] exp_d;

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h10] = 32'h2402_0001;   // address 0x40
    mem[8'h11] = 32'h1111_2222;   // address 0x44
    ram_rdata = '0;
    rst = 1'b1; inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;

    // Reset
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    idle();
    chk("rst_inst_rvalid", inst_rvalid, 0);
    chk("rst_data_rvalid", data_rvalid, 0);
    chk("rst_stallreq", stallreq, 0);
    chk("idle_ram_en", ram_en, 0);
    chk("idle_ram_addr", ram_addr, 0);
    chk("rst_starve_cnt", dut.starve_cnt, 0);

    // Fetch only
    cyc(1'b0, 1'b1, 32'h40, 1'b0, '0, '0, '0);
    chk("fetch_gnt", inst_gnt, 1);
    chk("fetch_ram_en", ram_en, 1);
    chk("fetch_ram_addr", ram_addr, 32'h40);
    chk("fetch_ram_wen", ram_wen, 0);
    chk("fetch_stall", stallreq, 0);
    idle();
    chk("fetch_rvalid", inst_rvalid, 1);
    chk("fetch_rdata", inst_rdata, 32'h2402_0001);
    chk("fetch_data_rvalid", data_rvalid, 0);
    chk("fetch_stall2", stallreq, 0);

    // Store then load
    cyc(1'b0, 1'b0, '0, 1'b1, 4'b1111, 32'h100, 32'hDEAD_BEEF);
    chk("st_gnt", data_gnt, 1);
    chk("st_ram_wen", ram_wen, 4'b1111);
    chk("st_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    cyc(1'b0, 1'b0, '0, 1'b1, 4'b0000, 32'h100, '0);
    chk("ld_gnt", data_gnt, 1);
    chk("st_no_rvalid", data_rvalid, 0);
    idle();
    chk("ld_rvalid", data_rvalid, 1);
    chk("ld_rdata", data_rdata, 32'hDEAD_BEEF);

    // Contention: two cycles both requesting, then data drops
    for (int c = 0; c < 2; c++) begin
      cyc(1'b0, 1'b1, 32'h40, 1'b1, 4'b0000, 32'h100, '0);
      chk("cont_data_gnt", data_gnt, 1);
      chk("cont_inst_gnt", inst_gnt, 0);
      chk("cont_stall", stallreq, 1);
      chk("cont_ram_addr", ram_addr, 32'h100);
    end
    cyc(1'b0, 1'b1, 32'h40, 1'b0, '0, '0, '0);
    chk("cont_fetch_gnt", inst_gnt, 1);
    chk("cont_stall_clr", stallreq, 0);
    chk("cont_ld_rvalid", data_rvalid, 1);
    chk("cont_ld_rdata", data_rdata, 32'hDEAD_BEEF);
    idle();
    chk("cont_inst_rvalid", inst_rvalid, 1);
    chk("cont_inst_rdata", inst_rdata, 32'h2402_0001);

    // Starvation: both held; data writes 0x200 with wen 0011, fetch 0x48
    exp_d = 6'b101111;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 1'b1, 32'h48, 1'b1, 4'b0011, 32'h200, 32'hA5A5_5A5A);
      chk("starve_data_gnt", data_gnt, exp_d[c]);
      chk("starve_inst_gnt", inst_gnt, !exp_d[c]);
      chk("starve_stall", stallreq, 1);
      chk("starve_ram_wen", ram_wen, exp_d[c] ? 4'b0011 : 4'b0000);
      chk("starve_ram_addr", ram_addr, exp_d[c] ? 32'h200 : 32'h48);
    end
    idle();
    chk("starve_inst_rvalid", inst_rvalid, 0);
    chk("starve_data_rvalid", data_rvalid, 0);

    // Interleaving I, D(read), I
    cyc(1'b0, 1'b1, 32'h40, 1'b0, '0, '0, '0);
    chk("il_i0_gnt", inst_gnt, 1);
    cyc(1'b0, 1'b0, '0, 1'b1, 4'b0000, 32'h100, '0);
    chk("il_d_gnt", data_gnt, 1);
    chk("il_i0_rvalid", inst_rvalid, 1);
    chk("il_i0_rdata", inst_rdata, 32'h2402_0001);
    chk("il_i0_drv", data_rvalid, 0);
    cyc(1'b0, 1'b1, 32'h44, 1'b0, '0, '0, '0);
    chk("il_i1_gnt", inst_gnt, 1);
    chk("il_d_rvalid", data_rvalid, 1);
    chk("il_d_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("il_d_irv", inst_rvalid, 0);
    idle();
    chk("il_i1_rvalid", inst_rvalid, 1);
    chk("il_i1_rdata", inst_rdata, 32'h1111_2222);
    chk("il_i1_drv", data_rvalid, 0);

    // Partial store result check: 0x200 held 0, low two bytes written
    cyc(1'b0, 1'b0, '0, 1'b1, 4'b0000, 32'h200, '0);
    idle();
    chk("pstore_rdata", data_rdata, 32'h0000_5A5A);

    // Reset mid-read
    cyc(1'b0, 1'b0, '0, 1'b1, 4'b0000, 32'h100, '0);
    chk("rmr_gnt", data_gnt, 1);
    cyc(1'b1, 1'b0, '0, 1'b0, '0, '0, '0);
    cyc(1'b0, 1'b1, 32'h40, 1'b0, '0, '0, '0);
    chk("rmr_rvalid_drop", data_rvalid, 0);
    chk("rmr_starve_cnt", dut.starve_cnt, 0);
    chk("rmr_fetch_gnt", inst_gnt, 1);
    idle();
    chk("rmr_inst_rvalid", inst_rvalid, 1);
    chk("rmr_no_late_rvalid", data_rvalid, 0);
    idle();
    chk("rmr_quiet_irv", inst_rvalid, 0);
    chk("rmr_quiet_drv", data_rvalid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Shares one single-port synchronous SRAM (1-cycle read latency) between the instruction-fetch requester (pc_reg/if_id) and the data requester (mem stage) for the unified-memory build. It grants at most one access per cycle, routes each read response back to its owner one cycle later, and raises a stall request to ctrl while any requester is held off. Data wins by default. A bounded starvation counter guarantees that fetch makes progress.

## Interface
Parameters:
- ADDR_W, 32, address width (physical, post-mmu)
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- STARVE_MAX, 4, consecutive denied fetch cycles before fetch is forced to win (1..15)

Ports (reset is synchronous and active-high on `rst`, single clock `clk`):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- inst_req  in  1  fetch request
- inst_addr  in  ADDR_W  fetch address
- inst_gnt  out  1  fetch accepted this cycle
- inst_rvalid  out  1  fetch data valid
- inst_rdata  out  DATA_W  fetch data
- data_req  in  1  data request
- data_wen  in  DATA_W/8  byte write enables; 0 = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  data accepted this cycle
- data_rvalid  out  1  load data valid (reads only)
- data_rdata  out  DATA_W  load data
- ram_en  out  1  SRAM enable
- ram_wen  out  DATA_W/8  SRAM byte write enables
- ram_addr  out  ADDR_W  SRAM address
- ram_wdata  out  DATA_W  SRAM write data
- ram_rdata  in  DATA_W  SRAM read data, valid the cycle after ram_en with ram_wen=0
- stallreq  out  1  to ctrl: a request is pending and not granted

## Operation
- Selection is combinational each cycle:
  - If `force_inst` (starve_cnt == STARVE_MAX) and inst_req are both set, fetch is selected.
  - Otherwise, if data_req is set, data is selected.
  - Otherwise, if inst_req is set, fetch is selected.
  - Otherwise nothing is selected.
- gnt = req & selected. ram_en = inst_gnt | data_gnt. ram_* fields come from the selected requester. When nothing is selected, ram_en=0, ram_wen=0, ram_addr/ram_wdata=0.
- A fetch always drives ram_wen=0.
- Response tag register `resp_owner` (NONE, INST, DATA) is loaded every cycle:
  - INST if inst_gnt.
  - DATA if data_gnt and data_wen==0.
  - NONE otherwise; data writes produce no response.
- inst_rvalid = (resp_owner==INST). data_rvalid = (resp_owner==DATA). Both rdata outputs pass ram_rdata through; their value is don't-care when the matching rvalid is low (bench must not check it).
- Starvation counter `starve_cnt`, width 4:
  - Increments, saturating at STARVE_MAX, when inst_req & ~inst_gnt.
  - Clears when inst_gnt or ~inst_req.
- stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt).
- Requesters hold req/addr/wen/wdata stable until granted. The arbiter does not latch request fields.

## Timing
- Reset values:
  - resp_owner=NONE and starve_cnt=0, so inst_rvalid=0 and data_rvalid=0 in the cycle after rst.
  - gnt, ram_* and stallreq are combinational and follow the rules above during reset.
- Grant latency is 0 cycles (same cycle as req when selected). Read-data latency is 1 cycle after grant.
- Throughput is one access per cycle. Back-to-back grants to the same or alternating owners are legal, and each response tag advances independently of the next grant.
- Simultaneous requests: data granted, fetch stalled. After STARVE_MAX consecutive denied cycles, the next cycle grants fetch and denies data (data stallreq=1); starve_cnt then returns to 0.
- rst asserted with a response outstanding: the response is dropped, rvalid=0 the next cycle, and no late rvalid ever appears.
- Request withdrawn before grant (flush): starve_cnt clears, and no response is issued.

## Structure
- Shared package: `resp_owner_t` enum (NONE=2'd0, INST=2'd1, DATA=2'd2) and the default widths.
- Sub-module: none needed. The counter, tag register and select mux fit in one module of about 150 lines.

## Test plan
- Fetch only: inst_req=1, addr 0x0000_0040 with mem[0x40]=0x2402_0001. Required: inst_gnt=1 the same cycle; the next cycle inst_rvalid=1 and inst_rdata=0x2402_0001; stallreq=0 throughout.
- Store then load: data write wen=4'b1111, addr 0x100, wdata=0xDEAD_BEEF, followed by a read of 0x100. Required: the write gives no data_rvalid; the read gives data_rvalid=1 with 0xDEADBEEF one cycle after its grant.
- Contention: inst_req and data_req held for 2 cycles. Required: data granted in both cycles, inst_gnt=0, stallreq=1; fetch granted in cycle 3 once data_req drops.
- Starvation with STARVE_MAX=4, both requests held continuously. Required: data granted in cycles 0–3; fetch granted in cycle 4 with data_gnt=0; data granted again in cycle 5.
- Interleaving: alternating single-cycle grants I, D(read), I. Required: the rvalid sequence is inst, data, inst, with each rdata matching its own address.
- Reset mid-read: rst asserted in the cycle after a data read grant. Required: data_rvalid=0 the next cycle, starve_cnt=0, and the first post-reset fetch is granted immediately.
